csa_key_sched_ctrl: RTL

- Sequences and shares one CSA `key_schedule` engine between N_REQ requesters, e.g. per-channel odd/even control-word loaders.
- Arbitrates round-robin, launches one expansion per grant and waits for completion.
- Writes the 448-bit expanded key into the key table at {slot, parity}, then acks the requester.
- Sits between the CW-load logic and the key table feeding the block/stream ciphers.

---
 rtl/csa_pkg.sv | 17 +
 rtl/csa_rr_arb.sv | 39 +++
 rtl/csa_key_sched_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the CSA key-schedule sequencer: datapath widths,
// FSM state encoding and the default watchdog limit.
package csa_pkg;

    localparam int CK_W            = 64;   // control word width
    localparam int KK_W            = 448;  // expanded key width (56 bytes)
    localparam int TIMEOUT_DEFAULT = 31;   // WAIT cycles before abort (watchdog build)

    // Sequencer states; encoding is fixed so it can be observed on a debug bus.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_WRITE  = 2'd3
    } ks_state_e;

endpackage : csa_pkg

// File: rtl/csa_rr_arb.sv
// Combinational round-robin picker: returns the first asserted request at or
// after rr_ptr_i, wrapping from N_REQ-1 back to 0.
module csa_rr_arb #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o
);

    // One extra bit so rr_ptr + offset can exceed N_REQ-1 before the wrap.
    localparam logic [IDX_W:0] N_REQ_W = (IDX_W + 1)'(N_REQ);

    logic [IDX_W:0] pos_s;

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        pos_s       = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            pos_s = {1'b0, rr_ptr_i} + (IDX_W + 1)'(off);
            if (pos_s >= N_REQ_W) begin
                pos_s = pos_s - N_REQ_W;
            end else begin
                pos_s = pos_s;
            end
            if (req_i[pos_s[IDX_W-1:0]]) begin
                gnt_idx_o   = pos_s[IDX_W-1:0];
                gnt_valid_o = 1'b1;
            end else begin
                gnt_valid_o = gnt_valid_o;
            end
        end
    end

endmodule : csa_rr_arb

// File: rtl/csa_key_sched_ctrl.sv
// Shares one external CSA key_schedule engine between N_REQ requesters.
// Round-robin grant, one expansion per grant, 448-bit result written to the
// key table at {slot, parity}, then a one-cycle ack to the requester.
// Build option: define CSA_KS_TIMEOUT_EN to add a WAIT-state watchdog that
// aborts a hung expansion after TIMEOUT cycles and pulses err[gnt].
module csa_key_sched_ctrl
    import csa_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int SLOT_W  = 4,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*CK_W-1:0]   req_ck,
    input  logic [N_REQ*SLOT_W-1:0] req_slot,
    input  logic [N_REQ-1:0]        req_par,
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        err,
    output logic                    ks_start,
    output logic [CK_W-1:0]         ks_ck,
    input  logic                    ks_busy,
    input  logic                    ks_done,
    input  logic [KK_W-1:0]         ks_kk,
    output logic                    kt_we,
    output logic [SLOT_W-1:0]       kt_slot,
    output logic                    kt_par,
    output logic [KK_W-1:0]         kt_data,
    output logic                    idle
);

    localparam int             IDX_W    = $clog2(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    // The watchdog counter is 5 bits wide, so the limit must fit in it.
    if ((TIMEOUT < 32'sd1) || (TIMEOUT > 32'sd32)) begin : g_bad_timeout
        $error("csa_key_sched_ctrl: TIMEOUT must be in 1..32");
    end

    // Next round-robin start: one past the requester just serviced.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
        if (g == LAST_IDX) begin
            next_ptr = '0;
        end else begin
            next_ptr = g + IDX_W'(1'b1);
        end
    endfunction

    ks_state_e         state_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  gnt_q;
    logic [CK_W-1:0]   ck_q;
    logic [SLOT_W-1:0] slot_q;
    logic              par_q;
    logic              ks_start_q;
    logic              kt_we_q;
    logic [KK_W-1:0]   kt_data_q;
    logic [N_REQ-1:0]  ack_q;
    logic              idle_q;

    logic [IDX_W-1:0]  arb_idx_s;
    logic              arb_valid_s;
    logic [CK_W-1:0]   sel_ck_s;
    logic [SLOT_W-1:0] sel_slot_s;
    logic              sel_par_s;

`ifdef CSA_KS_TIMEOUT_EN
    localparam logic [4:0] TO_LAST = 5'(TIMEOUT - 32'sd1);
    logic [4:0]       to_cnt_q;
    logic [N_REQ-1:0] err_q;
`endif

    csa_rr_arb #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i       (req),
        .rr_ptr_i    (rr_ptr_q),
        .gnt_idx_o   (arb_idx_s),
        .gnt_valid_o (arb_valid_s)
    );

    // Mux the winning requester's control word, slot and parity.
    always_comb begin
        sel_ck_s   = '0;
        sel_slot_s = '0;
        sel_par_s  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_idx_s == IDX_W'(i)) begin
                sel_ck_s   = req_ck[i*CK_W +: CK_W];
                sel_slot_s = req_slot[i*SLOT_W +: SLOT_W];
                sel_par_s  = req_par[i];
            end else begin
                sel_par_s  = sel_par_s;
            end
        end
    end

    // Sequencer FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            ck_q       <= '0;
            slot_q     <= '0;
            par_q      <= 1'b0;
            ks_start_q <= 1'b0;
            kt_we_q    <= 1'b0;
            kt_data_q  <= '0;
            ack_q      <= '0;
            idle_q     <= 1'b1;
`ifdef CSA_KS_TIMEOUT_EN
            to_cnt_q   <= '0;
            err_q      <= '0;
`endif
        end else begin
            ks_start_q <= 1'b0;
            kt_we_q    <= 1'b0;
            ack_q      <= '0;
`ifdef CSA_KS_TIMEOUT_EN
            err_q      <= '0;
`endif
            case (state_q)
                ST_IDLE: begin
                    // Request lines are only looked at here; the latch keeps
                    // the job alive even if the requester drops req later.
                    if (arb_valid_s) begin
                        gnt_q   <= arb_idx_s;
                        ck_q    <= sel_ck_s;
                        slot_q  <= sel_slot_s;
                        par_q   <= sel_par_s;
                        state_q <= ST_LAUNCH;
                        idle_q  <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        idle_q  <= 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    // After a reset the engine may still be finishing an old
                    // job, so never start it while it reports busy.
                    if (!ks_busy) begin
                        ks_start_q <= 1'b1;
                        state_q    <= ST_WAIT;
`ifdef CSA_KS_TIMEOUT_EN
                        to_cnt_q   <= '0;
`endif
                    end else begin
                        state_q    <= ST_LAUNCH;
                    end
                    idle_q <= 1'b0;
                end
                ST_WAIT: begin
                    if (ks_done) begin
                        kt_data_q     <= ks_kk;
                        kt_we_q       <= 1'b1;
                        ack_q[gnt_q]  <= 1'b1;
                        state_q       <= ST_WRITE;
                        idle_q        <= 1'b0;
                    end
`ifdef CSA_KS_TIMEOUT_EN
                    else if (to_cnt_q == TO_LAST) begin
                        err_q[gnt_q]  <= 1'b1;
                        rr_ptr_q      <= next_ptr(gnt_q);
                        to_cnt_q      <= '0;
                        state_q       <= ST_IDLE;
                        idle_q        <= 1'b1;
                    end else begin
                        to_cnt_q      <= to_cnt_q + 5'd1;
                        state_q       <= ST_WAIT;
                        idle_q        <= 1'b0;
                    end
`else
                    else begin
                        state_q       <= ST_WAIT;
                        idle_q        <= 1'b0;
                    end
`endif
                end
                ST_WRITE: begin
                    // kt_we and ack are high during this cycle.
                    rr_ptr_q <= next_ptr(gnt_q);
                    state_q  <= ST_IDLE;
                    idle_q   <= 1'b1;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    idle_q   <= 1'b1;
                end
            endcase
        end
    end

    assign ack      = ack_q;
    assign ks_start = ks_start_q;
    assign ks_ck    = ck_q;
    assign kt_we    = kt_we_q;
    assign kt_slot  = slot_q;
    assign kt_par   = par_q;
    assign kt_data  = kt_data_q;
    assign idle     = idle_q;
`ifdef CSA_KS_TIMEOUT_EN
    assign err      = err_q;
`else
    assign err      = '0;
`endif

endmodule : csa_key_sched_ctrl
